// File: rtl/ball_motion.sv
// Pong ball engine: advances the ball once per frame during vertical blanking,
// bounces it off walls and paddles, flags misses and draws the ball pixel.
module ball_motion #(
    parameter int H_RES        = 800,
    parameter int V_RES        = 600,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 4,
    parameter int BAR1_X       = 15,
    parameter int BAR2_X       = 775,
    parameter int BAR_W        = 10,
    parameter int BAR_H        = 80,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_active,
    input  logic       i_enable,
    input  logic [9:0] i_bar1_y,
    input  logic [9:0] i_bar2_y,
    output logic       o_color,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic       o_score1,
    output logic       o_score2
);

    localparam int X0 = (H_RES - BALL_SIZE) / 2;
    localparam int Y0 = (V_RES - BALL_SIZE) / 2;
    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [10:0] X_MAX = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] BS_M1 = 11'(BALL_SIZE - 1);
    localparam logic signed [10:0] STEP  = 11'(SPEED);
    localparam logic signed [10:0] L_LO  = 11'(BAR1_X);
    localparam logic signed [10:0] L_HI  = 11'(BAR1_X + BAR_W - 1);
    localparam logic signed [10:0] R_LO  = 11'(BAR2_X);
    localparam logic signed [10:0] R_HI  = 11'(BAR2_X + BAR_W - 1);

    typedef enum logic [1:0] {S_SERVE, S_RUN, S_MOVE, S_HIT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;   // 1 = towards larger coordinate
    logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
    logic               s1_q, s1_d, s2_q, s2_d;

    logic               tick;
    logic               wall_top, wall_bot;
    logic [10:0]        y_clamp, ball_bot;
    logic [10:0]        bar1_top, bar1_bot, bar2_top, bar2_bot;
    logic               ov1, ov2, hit_l, hit_r, miss_l, miss_r;

    assign tick = (i_x == 10'd0) && (i_y == 10'(V_RES));

    // Collision terms evaluate the candidate position held in nx_q/ny_q.
    always_comb begin
        wall_top = (ny_q < 11'sd0);
        wall_bot = (ny_q > Y_MAX);
        y_clamp  = wall_top ? 11'd0 : (wall_bot ? Y_MAX : ny_q);
        ball_bot = y_clamp + 11'(BALL_SIZE - 1);
        bar1_top = {1'b0, i_bar1_y};
        bar1_bot = {1'b0, i_bar1_y} + 11'(BAR_H - 1);
        bar2_top = {1'b0, i_bar2_y};
        bar2_bot = {1'b0, i_bar2_y} + 11'(BAR_H - 1);
        ov1      = (y_clamp <= bar1_bot) && (ball_bot >= bar1_top);
        ov2      = (y_clamp <= bar2_bot) && (ball_bot >= bar2_top);
        hit_l    = !dx_q && (nx_q <= L_HI) && (nx_q + BS_M1 >= L_LO) && ov1;
        hit_r    =  dx_q && (nx_q + BS_M1 >= R_LO) && (nx_q <= R_HI) && ov2;
        miss_l   = (nx_q < 11'sd0) && !hit_l;
        miss_r   = (nx_q > X_MAX) && !hit_r;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        s1_d    = 1'b0;
        s2_d    = 1'b0;
        case (state_q)
            S_SERVE: begin
                if (tick && i_enable) begin
                    if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (tick && i_enable) state_d = S_MOVE;
            end
            S_MOVE: begin
                nx_d    = dx_q ? $signed({1'b0, x_q}) + STEP : $signed({1'b0, x_q}) - STEP;
                ny_d    = dy_q ? $signed({1'b0, y_q}) + STEP : $signed({1'b0, y_q}) - STEP;
                state_d = S_HIT;
            end
            default: begin
                y_d     = y_clamp[9:0];
                dy_d    = wall_top ? 1'b1 : (wall_bot ? 1'b0 : dy_q);
                state_d = S_RUN;
                if (hit_l) begin
                    x_d  = 10'(BAR1_X + BAR_W);
                    dx_d = 1'b1;
                end else if (hit_r) begin
                    x_d  = 10'(BAR2_X - BALL_SIZE);
                    dx_d = 1'b0;
                end else if (miss_l) begin
                    s2_d    = 1'b1;
                    x_d     = 10'(X0);
                    y_d     = 10'(Y0);
                    dx_d    = 1'b1;
                    state_d = S_SERVE;
                end else if (miss_r) begin
                    s1_d    = 1'b1;
                    x_d     = 10'(X0);
                    y_d     = 10'(Y0);
                    dx_d    = 1'b0;
                    state_d = S_SERVE;
                end else begin
                    x_d = nx_q[9:0];
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_SERVE;
            cnt_q   <= '0;
            x_q     <= 10'(X0);
            y_q     <= 10'(Y0);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            nx_q    <= '0;
            ny_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    // Zero-latency pixel test so the ball lines up with the paddle colour path.
    assign o_color = i_active
                   && (i_x >= x_q) && ({1'b0, i_x} < {1'b0, x_q} + 11'(BALL_SIZE))
                   && (i_y >= y_q) && ({1'b0, i_y} < {1'b0, y_q} + 11'(BALL_SIZE));

    assign o_ball_x = x_q;
    assign o_ball_y = y_q;
    assign o_score1 = s1_q;
    assign o_score2 = s2_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus queues expected ball state per frame
// tick or probe, and a monitor process pops and compares when the DUT responds.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = 10'd100;
    logic [9:0] y = 10'd650;
    logic       active = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] bar1 = 10'd400;
    logic [9:0] bar2 = 10'd0;
    logic       color;
    logic [9:0] bx, by;
    logic       s1, s2;

    logic probe_v = 1'b0, scan_en = 1'b0, scan_done = 1'b0, fin = 1'b0;

    typedef struct {
        int x;
        int y;
        bit s1;
        bit s2;
        bit chk_pos;
        bit chk_col;
        bit col;
    } exp_t;

    exp_t pos_q[$];
    exp_t probe_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_x      (x),
        .i_y      (y),
        .i_active (active),
        .i_enable (enable),
        .i_bar1_y (bar1),
        .i_bar2_y (bar2),
        .o_color  (color),
        .o_ball_x (bx),
        .o_ball_y (by),
        .o_score1 (s1),
        .o_score2 (s2)
    );

    function automatic exp_t mk(input int ex, input int ey, input bit es1, input bit es2,
                                input bit cp, input bit cc, input bit ec);
        exp_t e;
        e.x = ex; e.y = ey; e.s1 = es1; e.s2 = es2;
        e.chk_pos = cp; e.chk_col = cc; e.col = ec;
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        bit [4:0] h;
        bit       pend_zero;
        int       scan_cnt;
        int       tick_no;
        exp_t     e;
        h = '0; pend_zero = 1'b0; scan_cnt = 0; tick_no = 0;
        forever begin
            @(negedge clk);
            h = {h[3:0], (x == 10'd0 && y == 10'd600)};
            if (h[4] && pend_zero) begin
                n_vec++;
                pend_zero = 1'b0;
                if (s1 !== 1'b0 || s2 !== 1'b0) begin
                    n_err++;
                    $display("FAIL pulse_width tick %0d: score1=%b score2=%b, required 0 0", tick_no, s1, s2);
                end
            end
            if (h[3]) begin
                tick_no++;
                n_vec++;
                if (pos_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tick %0d: no expectation queued", tick_no);
                end else begin
                    e = pos_q.pop_front();
                    pend_zero = e.s1 || e.s2;
                    if (bx !== 10'(e.x) || by !== 10'(e.y) || s1 !== e.s1 || s2 !== e.s2) begin
                        n_err++;
                        $display("FAIL tick %0d: got (%0d,%0d) s1=%b s2=%b, required (%0d,%0d) s1=%b s2=%b",
                                 tick_no, bx, by, s1, s2, e.x, e.y, e.s1, e.s2);
                    end
                end
            end
            if (probe_v) begin
                n_vec++;
                if (probe_q.size() == 0) begin
                    n_err++;
                    $display("FAIL probe: no expectation queued");
                end else begin
                    e = probe_q.pop_front();
                    if (e.chk_pos && (bx !== 10'(e.x) || by !== 10'(e.y) || s1 !== e.s1 || s2 !== e.s2)) begin
                        n_err++;
                        $display("FAIL probe_pos: got (%0d,%0d) s1=%b s2=%b, required (%0d,%0d) s1=%b s2=%b",
                                 bx, by, s1, s2, e.x, e.y, e.s1, e.s2);
                    end
                    if (e.chk_col && color !== e.col) begin
                        n_err++;
                        $display("FAIL probe_color at (%0d,%0d) active=%b: got %b, required %b",
                                 x, y, active, color, e.col);
                    end
                end
            end
            if (scan_en && color === 1'b1) scan_cnt++;
            if (scan_done) begin
                n_vec++;
                if (scan_cnt != 64) begin
                    n_err++;
                    $display("FAIL scan_count: got %0d ball pixels, required 64", scan_cnt);
                end
                scan_cnt = 0;
            end
            if (fin) begin
                n_vec++;
                if (pos_q.size() != 0 || probe_q.size() != 0) begin
                    n_err++;
                    $display("FAIL drain: %0d tick and %0d probe expectations left, required 0 0",
                             pos_q.size(), probe_q.size());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        @(posedge clk); #1;
        x = 10'd100; y = 10'd650;
    endtask

    task automatic frame(input int ex, input int ey, input bit es1, input bit es2,
                         input bit drop_en, input bit rst_hit);
        pos_q.push_back(mk(ex, ey, es1, es2, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1; x = 10'd0; y = 10'd600;
        @(posedge clk); #1; x = 10'd100; y = 10'd650;
        if (drop_en) enable = 1'b0;
        @(posedge clk); #1; if (rst_hit) rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        idle();
        idle();
    endtask

    task automatic probe(input int px, input int py, input bit act, input exp_t e);
        @(posedge clk); #1;
        x = 10'(px); y = 10'(py); active = act; probe_v = 1'b1;
        probe_q.push_back(e);
        @(posedge clk); #1;
        probe_v = 1'b0; active = 1'b0; x = 10'd100; y = 10'd650;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        probe(100, 650, 1'b0, mk(396, 296, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic serve();
        for (int i = 0; i < 60; i++) frame(396, 296, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : stim
        // Phase A: serve, travel right, bottom-wall bounce at y=592, right miss.
        enable = 1'b1; bar1 = 10'd400; bar2 = 10'd0;
        do_reset();
        serve();
        for (int n = 1; n <= 99; n++)
            frame(396 + 4*n, (n <= 74) ? 296 + 4*n : 592 - 4*(n - 75), 1'b0, 1'b0, 1'b0, 1'b0);
        frame(396, 296, 1'b1, 1'b0, 1'b0, 1'b0);

        // Phase B: serve leftward, top-wall bounce, left paddle return.
        bar1 = 10'd50;
        serve();
        for (int m = 1; m <= 92; m++)
            frame(396 - 4*m, (m <= 74) ? 296 - 4*m : 4*(m - 75), 1'b0, 1'b0, 1'b0, 1'b0);
        frame(25, 72, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(29, 76, 1'b0, 1'b0, 1'b0, 1'b0);

        // Phase C: colour, freeze, late disable, reset during the update cycle.
        do_reset();
        @(posedge clk); #1; scan_en = 1'b1; active = 1'b1;
        for (int yy = 280; yy < 320; yy++)
            for (int xx = 380; xx < 420; xx++) begin
                x = 10'(xx); y = 10'(yy);
                @(posedge clk); #1;
            end
        scan_en = 1'b0; active = 1'b0; scan_done = 1'b1; x = 10'd100; y = 10'd650;
        @(posedge clk); #1; scan_done = 1'b0;
        probe(400, 300, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        probe(400, 300, 1'b0, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        probe(396, 296, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        probe(403, 303, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        probe(395, 300, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        probe(404, 300, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        probe(400, 295, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        probe(400, 304, 1'b1, mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0));
        serve();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) frame(396, 296, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        frame(400, 300, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(404, 304, 1'b0, 1'b0, 1'b1, 1'b0);
        enable = 1'b1;
        frame(396, 296, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(396, 296, 1'b0, 1'b0, 1'b0, 1'b0);

        // Phase D: right paddle return, long run left, left miss.
        bar1 = 10'd400; bar2 = 10'd500;
        do_reset();
        serve();
        for (int n = 1; n <= 92; n++)
            frame(396 + 4*n, (n <= 74) ? 296 + 4*n : 592 - 4*(n - 75), 1'b0, 1'b0, 1'b0, 1'b0);
        frame(767, 520, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 191; k++)
            frame(767 - 4*k, (k <= 130) ? 520 - 4*k : 4*(k - 131), 1'b0, 1'b0, 1'b0, 1'b0);
        frame(396, 296, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(396, 296, 1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clk); #1; fin = 1'b1;
        @(posedge clk); #1; fin = 1'b0;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
